// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with 4-entry register file, scoreboard and operand bypass
module decode_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] rs_data1,
    output logic [DATA_W-1:0] rs_data2,
    output logic [1:0]        immediate,
    output logic [1:0]        rd_addr
);

    // Entry 0 is reset to zero and never written, so it always reads as 0.
    logic [DATA_W-1:0] rf [4];
    // Bit 0 is never set; r0 can therefore never cause a stall.
    logic [3:0]        pending;

    logic [1:0]        rd_idx;
    logic [1:0]        rs1_idx;
    logic [1:0]        rs2_idx;
    logic              wb_hit1;
    logic              wb_hit2;
    logic              hazard;
    logic              capture;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign rd_idx  = instr[5:4];
    assign rs1_idx = instr[3:2];
    assign rs2_idx = instr[1:0];

    // Operand read with same-cycle writeback forwarding; a matching writeback also resolves the hazard.
    always_comb begin
        wb_hit1 = wb_en && (wb_addr == rs1_idx) && (rs1_idx != 2'd0);
        wb_hit2 = wb_en && (wb_addr == rs2_idx) && (rs2_idx != 2'd0);
        op1     = wb_hit1 ? wb_data : rf[rs1_idx];
        op2     = wb_hit2 ? wb_data : rf[rs2_idx];
        hazard  = (pending[rs1_idx] && !wb_hit1) || (pending[rs2_idx] && !wb_hit2);
    end

    assign instr_ready = (!out_valid || out_ready) && !hazard;
    assign capture     = instr_valid && instr_ready;

    // Register file writeback; writes to r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 2'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: writeback clears, issue sets; the later set wins on a same-bit collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 4'b0000;
        end else begin
            if (wb_en) begin
                pending[wb_addr] <= 1'b0;
            end
            if (capture && (rd_idx != 2'd0)) begin
                pending[rd_idx] <= 1'b1;
            end
        end
    end

    // Output stage: load on capture, drop valid when consumed, otherwise hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_op    <= 2'b00;
            rd_addr   <= 2'b00;
            immediate <= 2'b00;
            rs_data1  <= '0;
            rs_data2  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            alu_op    <= instr[7:6];
            rd_addr   <= rd_idx;
            immediate <= instr[1:0];
            rs_data1  <= op1;
            rs_data2  <= op2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] alu_op;
    logic [7:0] rs_data1;
    logic [7:0] rs_data2;
    logic [1:0] immediate;
    logic [1:0] rd_addr;

    int n_vec = 0;
    int n_bad = 0;

    decode_stage #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .rs_data1    (rs_data1),
        .rs_data2    (rs_data2),
        .immediate   (immediate),
        .rd_addr     (rd_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ins, input logic we,
                         input logic [1:0] wa, input logic [7:0] wd, input logic ordy);
        instr_valid = v;
        instr       = ins;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        out_ready   = ordy;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] op, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [1:0] imm, input logic [1:0] rd);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".alu_op"}, alu_op, op);
        check({tag, ".rs1"}, rs_data1, d1);
        check({tag, ".rs2"}, rs_data2, d2);
        check({tag, ".imm"}, immediate, imm);
        check({tag, ".rd"}, rd_addr, rd);
    endtask

    logic [7:0] s_ins [4];
    logic [7:0] s_d1  [4];
    logic [7:0] s_d2  [4];

    initial begin
        s_ins[0] = 8'h04; s_d1[0] = 8'h10; s_d2[0] = 8'h00;
        s_ins[1] = 8'h49; s_d1[1] = 8'hAA; s_d2[1] = 8'h10;
        s_ins[2] = 8'hCF; s_d1[2] = 8'h00; s_d2[2] = 8'h00;
        s_ins[3] = 8'h86; s_d1[3] = 8'h10; s_d2[3] = 8'hAA;

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 2'd0, 8'h00, 0);
        tick();
        check("rst.valid", out_valid, 0);
        check("rst.ready", instr_ready, 1);
        check("rst.rs1", rs_data1, 0);
        check("rst.alu", alu_op, 0);
        rst_n = 1'b1;

        // Load r1=5, r2=3, then ADD rd=r0 rs1=r1 rs2=r2
        drive(0, 8'h00, 1, 2'd1, 8'h05, 1); tick();
        drive(0, 8'h00, 1, 2'd2, 8'h03, 1); tick();
        drive(1, 8'h06, 0, 2'd0, 8'h00, 1);
        check("add.ready", instr_ready, 1);
        tick();
        check_out("add", 2'b00, 8'h05, 8'h03, 2'b10, 2'd0);

        // SUB rd=r1 reads pre-issue r1, then SLL on r1 stalls until writeback
        drive(1, 8'h55, 0, 2'd0, 8'h00, 1); tick();
        check_out("sub", 2'b01, 8'h05, 8'h05, 2'b01, 2'd1);
        drive(1, 8'h84, 0, 2'd0, 8'h00, 1);
        check("sll.stall0", instr_ready, 0);
        tick();
        check("sll.drain", out_valid, 0);
        check("sll.stall1", instr_ready, 0);
        drive(1, 8'h84, 1, 2'd1, 8'h10, 1);
        check("sll.bypass_ready", instr_ready, 1);
        tick();
        check_out("sll", 2'b10, 8'h10, 8'h00, 2'b00, 2'd0);

        // Issue 0x09 then hold it for 3 cycles with a r2 writeback during the hold
        drive(1, 8'h09, 0, 2'd0, 8'h00, 1); tick();
        check_out("hold0", 2'b00, 8'h03, 8'h10, 2'b01, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h4A, (i == 0), 2'd2, 8'hAA, 0);
            check("hold.ready", instr_ready, 0);
            tick();
            check_out("hold", 2'b00, 8'h03, 8'h10, 2'b01, 2'd0);
        end
        drive(1, 8'h4A, 0, 2'd0, 8'h00, 1); tick();
        check_out("after_hold", 2'b01, 8'hAA, 8'hAA, 2'b10, 2'd0);

        // Back-to-back stream of four hazard-free instructions
        for (int i = 0; i < 4; i++) begin
            drive(1, s_ins[i], 0, 2'd0, 8'h00, 1);
            check("stream.ready", instr_ready, 1);
            tick();
            check_out("stream", s_ins[i][7:6], s_d1[i], s_d2[i], s_ins[i][1:0], 2'd0);
        end
        drive(0, 8'h00, 0, 2'd0, 8'h00, 1); tick();
        check("drain.valid", out_valid, 0);
        check("drain.keep_rs1", rs_data1, 8'h10);
        check("drain.keep_rs2", rs_data2, 8'hAA);

        // r0 ignores writes, never bypasses, and rd=r0 never stalls
        drive(1, 8'h00, 1, 2'd0, 8'hFF, 1); tick();
        check("r0.rs1", rs_data1, 8'h00);
        drive(1, 8'h00, 0, 2'd0, 8'h00, 1);
        check("r0.nostall", instr_ready, 1);
        tick();
        check("r0.rs1b", rs_data1, 8'h00);

        // Same-cycle issue to r3 and writeback to r3: pending set wins
        drive(1, 8'h30, 1, 2'd3, 8'h77, 1); tick();
        drive(1, 8'h0C, 0, 2'd0, 8'h00, 1);
        check("setwin.stall", instr_ready, 0);
        tick();
        drive(1, 8'h0C, 1, 2'd3, 8'h22, 1); tick();
        check_out("setwin", 2'b00, 8'h22, 8'h00, 2'b00, 2'd0);

        // Reset in the middle of a stall with r1 pending
        drive(1, 8'h50, 0, 2'd0, 8'h00, 1); tick();
        drive(1, 8'h04, 0, 2'd0, 8'h00, 0);
        check("stall.ready", instr_ready, 0);
        rst_n = 1'b0;
        #2;
        check("arst.valid", out_valid, 0);
        check("arst.alu", alu_op, 0);
        check("arst.ready", instr_ready, 1);
        tick();
        rst_n = 1'b1;
        drive(1, 8'h04, 0, 2'd0, 8'h00, 1);
        check("post.ready", instr_ready, 1);
        tick();
        check_out("post", 2'b00, 8'h00, 8'h00, 2'b00, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
